pipeline_fetch_ctrl: RTL and testbench
======================================

Name: pipeline_fetch_ctrl

Overview:
Fetch-stage controller for the pipelined RISC-V core. It sequences the byte-addressed, combinational-read instruction memory. It owns the PC, selects the next PC (sequential, redirect from EX, or hold on stall), and loads the IF/ID pipeline register, inserting bubbles on redirect. It halts on misaligned or out-of-range fetch targets and reports the faulting address.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
IMEM_BYTES, 81, instruction-memory size in bytes; a fetch is legal iff PC+3 < IMEM_BYTES
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
imem_pc  out  32  address to instruction memory, equal to the PC register
imem_instr  in  32  instruction word returned combinationally for imem_pc
stall  in  1  hazard-unit hold: freeze PC and IF/ID
redirect  in  1  taken branch/jump from EX
redirect_pc  in  32  redirect target
if_id_pc  out  32  PC of the instruction in IF/ID
if_id_instr  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  controller is in HALT
fault  out  1  sticky fault flag, cleared on legal redirect out of HALT
fault_cause  out  2  01 misaligned, 10 out of range, 11 both, 00 none
fault_pc  out  32  address that caused the last fault
fetch_count  out  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (async): state=BOOT; pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; halted=0; fault=0; fault_cause=00; fault_pc=0; fetch_count=0.
- Legality check (comb): misaligned = addr[1:0]!=0. Out-of-range = (33-bit addr+3) >= IMEM_BYTES, so there is no 32-bit wrap.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset release. Outputs hold reset values; stall and redirect are ignored. Next state is RUN.
- RUN, priority redirect > stall > sequential:
  - redirect=1 (overrides stall): IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc=0).
    - Legal target: pc<=redirect_pc.
    - Illegal target: pc holds; fault<=1; fault_cause/fault_pc <= target info; state<=HALT.
  - stall=1, redirect=0: pc, IF/ID, and fetch_count all hold.
  - Otherwise, current pc legal: IF/ID <= {pc, imem_instr, valid=1}; pc<=pc+4 (mod 2^32); fetch_count+=1 (wraps).
  - Otherwise, current pc illegal (e.g. sequential run-off past the end): IF/ID <= bubble; fault<=1; fault_pc<=pc; state<=HALT.
- HALT: halted=1; pc holds; IF/ID stays bubble; stall is ignored.
  - redirect with legal target: pc<=target; fault<=0; fault_cause<=00; state<=RUN. The first fetch happens in the next cycle.
  - redirect with illegal target: stay in HALT; fault_pc/fault_cause are updated.
- Latency: instruction at PC p appears in IF/ID one clock edge after imem_pc=p with stall=0.
- The redirect bubble occupies one IF/ID slot. The target's instruction is valid two edges after redirect is sampled.
- imem_instr is sampled only in RUN on a legal sequential fetch; an X on it otherwise must not propagate.
- Reset asserted mid-operation (any state) returns to BOOT immediately, with all outputs at reset values.

Decomposition:
- Package fetch_pkg: NOP_INSTR constant, state enum {BOOT,RUN,HALT}, fault_cause codes.
- Sub-module fetch_addr_check (comb): addr -> misaligned, out_of_range, cause[1:0]. Instantiate it twice, once for the current pc and once for redirect_pc.

Test Plan:
- Reset, release, no stall for 6 cycles -> imem_pc 0,0,4,8,12,16 (BOOT holds 0); if_id_pc 0,4,8,12; fetch_count=4.
- stall=1 for 3 cycles at pc=8 -> imem_pc=8, IF/ID (pc 4) and fetch_count unchanged; fetch resumes at 8 after release.
- redirect=1, redirect_pc=0x20, with stall=1 in the same cycle -> next edge if_id_valid=0, instr=0x13, imem_pc=0x20; following edge if_id_pc=0x20, valid=1.
- redirect_pc=0x22 -> HALT, fault=1, fault_cause=01, fault_pc=0x22, imem_pc unchanged; then redirect_pc=0x10 -> RUN, fault=0, IF/ID pc=0x10 two edges later.
- Sequential run to pc=76 then 80 (IMEM_BYTES=81) -> 76 fetched valid; at 80 fault_cause=10, fault_pc=80, halted=1.
- Assert reset asynchronously mid-stream while in HALT with fault set -> all outputs return to reset values without a clock edge; BOOT then RUN from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the fetch-stage controller
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_RANGE     = 2'b10;
    localparam logic [1:0] CAUSE_BOTH      = 2'b11;

endpackage

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - combinational legality check of a fetch address
module fetch_addr_check
    import fetch_pkg::*;
#(
    parameter int IMEM_BYTES = 81
) (
    input  logic [31:0] addr,
    output logic        misaligned,
    output logic        out_of_range,
    output logic [1:0]  cause
);

    localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

    // The 33-bit sum keeps addresses near 2^32 from wrapping back into range.
    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = (({1'b0, addr} + 33'd3) >= LIMIT);
    assign cause        = {out_of_range, misaligned};

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// rtl/pipeline_fetch_ctrl.sv - PC sequencing and IF/ID loading for the fetch stage
module pipeline_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 81,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         pc_mis, pc_oor, rd_mis, rd_oor;
    logic [1:0]   pc_cause, rd_cause;
    logic         pc_legal, rd_legal;

    fetch_addr_check #(.IMEM_BYTES(IMEM_BYTES)) u_pc_check (
        .addr         (pc),
        .misaligned   (pc_mis),
        .out_of_range (pc_oor),
        .cause        (pc_cause)
    );

    fetch_addr_check #(.IMEM_BYTES(IMEM_BYTES)) u_rd_check (
        .addr         (redirect_pc),
        .misaligned   (rd_mis),
        .out_of_range (rd_oor),
        .cause        (rd_cause)
    );

    assign pc_legal = !(pc_mis || pc_oor);
    assign rd_legal = !(rd_mis || rd_oor);
    assign imem_pc  = pc;
    assign halted   = (state == ST_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            fault_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (redirect) begin
                        if_id_pc    <= 32'h0;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (rd_legal) begin
                            pc <= redirect_pc;
                        end else begin
                            fault       <= 1'b1;
                            fault_cause <= rd_cause;
                            fault_pc    <= redirect_pc;
                            state       <= ST_HALT;
                        end
                    end else if (!stall) begin
                        if (pc_legal) begin
                            // imem_instr is only captured here, so X elsewhere never enters IF/ID.
                            if_id_pc    <= pc;
                            if_id_instr <= imem_instr;
                            if_id_valid <= 1'b1;
                            pc          <= pc + 32'd4;
                            fetch_count <= fetch_count + 32'd1;
                        end else begin
                            if_id_pc    <= 32'h0;
                            if_id_instr <= NOP_INSTR;
                            if_id_valid <= 1'b0;
                            fault       <= 1'b1;
                            fault_cause <= pc_cause;
                            fault_pc    <= pc;
                            state       <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (redirect) begin
                        if (rd_legal) begin
                            pc          <= redirect_pc;
                            fault       <= 1'b0;
                            fault_cause <= CAUSE_NONE;
                            state       <= ST_RUN;
                        end else begin
                            fault_cause <= rd_cause;
                            fault_pc    <= redirect_pc;
                        end
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// tb/tb_pipeline_fetch_ctrl.sv - directed self-checking bench for pipeline_fetch_ctrl
module tb_pipeline_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc, imem_instr;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid, halted, fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc, fetch_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: word encodes its own address.
    assign imem_instr = {16'hC0DE, imem_pc[15:0]};

    pipeline_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".imem_pc"}, imem_pc, 32'h0);
        check({tag, ".if_id_pc"}, if_id_pc, 32'h0);
        check({tag, ".if_id_instr"}, if_id_instr, 32'h13);
        check({tag, ".if_id_valid"}, {31'h0, if_id_valid}, 32'h0);
        check({tag, ".halted"}, {31'h0, halted}, 32'h0);
        check({tag, ".fault"}, {31'h0, fault}, 32'h0);
        check({tag, ".fault_cause"}, {30'h0, fault_cause}, 32'h0);
        check({tag, ".fault_pc"}, fault_pc, 32'h0);
        check({tag, ".fetch_count"}, fetch_count, 32'h0);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        check({tag, ".if_id_pc"}, if_id_pc, pc);
        check({tag, ".if_id_instr"}, if_id_instr, {16'hC0DE, pc[15:0]});
        check({tag, ".if_id_valid"}, {31'h0, if_id_valid}, 32'h1);
        check({tag, ".fetch_count"}, fetch_count, cnt);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".if_id_pc"}, if_id_pc, 32'h0);
        check({tag, ".if_id_instr"}, if_id_instr, 32'h13);
        check({tag, ".if_id_valid"}, {31'h0, if_id_valid}, 32'h0);
    endtask

    logic [31:0] exp_pc [6] = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12, 32'd16};

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #3;
        check_reset_state("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Free run from reset: BOOT holds pc 0 for one extra sample.
        for (int k = 0; k < 6; k++) begin
            check($sformatf("seq%0d.imem_pc", k), imem_pc, exp_pc[k]);
            if (k == 0) check_reset_state("boot");
            if (k < 5) cycle();
        end
        check_ifid("seq5", 32'd12, 32'd4);

        // Stall: freeze at pc 24 with IF/ID holding pc 20 after two more fetches.
        cycle(); cycle();
        check_ifid("prestall", 32'd20, 32'd6);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("stall%0d.imem_pc", k), imem_pc, 32'd24);
            check_ifid($sformatf("stall%0d", k), 32'd20, 32'd6);
        end
        stall = 1'b0;
        cycle();
        check_ifid("unstall", 32'd24, 32'd7);
        check("unstall.imem_pc", imem_pc, 32'd28);

        // Redirect overrides a simultaneous stall.
        redirect = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
        cycle();
        check_bubble("redir");
        check("redir.imem_pc", imem_pc, 32'h20);
        check("redir.fetch_count", fetch_count, 32'd7);
        redirect = 1'b0; stall = 1'b0;
        cycle();
        check_ifid("redir_tgt", 32'h20, 32'd8);
        check("redir_tgt.imem_pc", imem_pc, 32'h24);

        // Misaligned redirect halts with pc held.
        redirect = 1'b1; redirect_pc = 32'h22;
        cycle();
        redirect = 1'b0;
        check("mis.halted", {31'h0, halted}, 32'h1);
        check("mis.fault", {31'h0, fault}, 32'h1);
        check("mis.fault_cause", {30'h0, fault_cause}, 32'h1);
        check("mis.fault_pc", fault_pc, 32'h22);
        check("mis.imem_pc", imem_pc, 32'h24);
        check_bubble("mis");

        // In HALT, stall is ignored and an illegal redirect updates fault info.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h101;
        cycle();
        check("both.halted", {31'h0, halted}, 32'h1);
        check("both.fault_cause", {30'h0, fault_cause}, 32'h3);
        check("both.fault_pc", fault_pc, 32'h101);
        check("both.imem_pc", imem_pc, 32'h24);

        // Legal redirect leaves HALT; first fetch one edge later.
        redirect_pc = 32'h10;
        cycle();
        redirect = 1'b0; stall = 1'b0;
        check("rec.halted", {31'h0, halted}, 32'h0);
        check("rec.fault", {31'h0, fault}, 32'h0);
        check("rec.fault_cause", {30'h0, fault_cause}, 32'h0);
        check("rec.fault_pc", fault_pc, 32'h101);
        check("rec.imem_pc", imem_pc, 32'h10);
        check_bubble("rec");
        cycle();
        check_ifid("rec_tgt", 32'h10, 32'd9);

        // Run off the end: 76 is the last legal word, 80 faults out of range.
        redirect = 1'b1; redirect_pc = 32'd72;
        cycle();
        redirect = 1'b0;
        check("end.imem_pc", imem_pc, 32'd72);
        cycle();
        check_ifid("end72", 32'd72, 32'd10);
        cycle();
        check_ifid("end76", 32'd76, 32'd11);
        check("end76.imem_pc", imem_pc, 32'd80);
        cycle();
        check("oor.halted", {31'h0, halted}, 32'h1);
        check("oor.fault", {31'h0, fault}, 32'h1);
        check("oor.fault_cause", {30'h0, fault_cause}, 32'h2);
        check("oor.fault_pc", fault_pc, 32'd80);
        check("oor.imem_pc", imem_pc, 32'd80);
        check("oor.fetch_count", fetch_count, 32'd11);
        check_bubble("oor");

        // Asynchronous reset in HALT, checked away from any clock edge.
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("arst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("boot2.imem_pc", imem_pc, 32'h0);
        check("boot2.halted", {31'h0, halted}, 32'h0);
        cycle();
        check("run2.imem_pc", imem_pc, 32'h0);
        check("run2.if_id_valid", {31'h0, if_id_valid}, 32'h0);
        cycle();
        check_ifid("run2", 32'h0, 32'd1);
        check("run2.imem_pc_next", imem_pc, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
